// File: rtl/tm1638_responder.sv
// ---------------------------------------------------------------------------
// tm1638_responder
//
// Device end of the three-wire LED&KEY link (strobe, serial clock,
// bidirectional data). The link is oversampled in the system clock domain.
// The block decodes data, address-set and display-control commands, holds
// the 16-byte display RAM, and shifts out a 4-byte key snapshot on key-read
// commands.
//
// Optional feature macro: TM1638_KEYSCAN_EN
//   defined     : key snapshot is taken from `keys`
//   not defined : `keys` is ignored and the snapshot reads as all zeros.
//                 The read phase still drives the data line, so the
//                 initiator's read timing is exercised.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   i_lk_clk     link serial clock from the initiator (asynchronous)
//   i_lk_stb     link strobe, active low (asynchronous)
//   i_lk_dio     link data as seen at the pad (asynchronous)
//   o_lk_dio     data driven back to the initiator
//   o_lk_dio_oe  output enable for o_lk_dio
//   keys         key state, byte n = keys[8n+7:8n]
//   ram_raddr    display RAM read address
//   ram_rdata    display RAM read data, registered, 1-cycle latency
//   display_on   display-control bit 3
//   brightness   display-control bits 2:0
//   frame_done   1-cycle pulse when a frame that wrote RAM is closed
// ---------------------------------------------------------------------------
module tm1638_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_lk_clk,
    input  logic        i_lk_stb,
    input  logic        i_lk_dio,
    output logic        o_lk_dio,
    output logic        o_lk_dio_oe,
    input  logic [31:0] keys,
    input  logic [3:0]  ram_raddr,
    output logic [7:0]  ram_rdata,
    output logic        display_on,
    output logic [2:0]  brightness,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_RDATA,
        S_IGNORE
    } state_t;

    // Synchronizers and edge-detect history
    logic [SYNC_STAGES-1:0] r_clkSync;
    logic [SYNC_STAGES-1:0] r_stbSync;
    logic [SYNC_STAGES-1:0] r_dioSync;
    logic                   r_clkPrev;
    logic                   r_stbPrev;

    // Protocol state
    state_t      r_state;
    logic [2:0]  r_bitCnt;
    logic [7:0]  r_shift;
    logic [3:0]  r_ptr;
    logic        r_fixed;
    logic [31:0] r_snap;
    logic [5:0]  r_rdIdx;
    logic        r_dio;
    logic        r_oe;
    logic        r_dispOn;
    logic [2:0]  r_bright;
    logic        r_frameDone;
    logic        r_wrote;

    // RAM and its post-reset clearing sequencer
    logic [7:0]  r_ram [16];
    logic [7:0]  r_ramRdata;
    logic        r_clearing;
    logic [3:0]  r_clearAddr;

    logic        w_clkCur;
    logic        w_stbCur;
    logic        w_dioCur;
    logic        w_stbFall;
    logic        w_stbRise;
    logic        w_clkRise;
    logic        w_clkFall;
    logic [7:0]  w_byte;
    logic [31:0] w_keyState;

    state_t      w_nState;
    logic [2:0]  w_nBitCnt;
    logic [7:0]  w_nShift;
    logic [3:0]  w_nPtr;
    logic        w_nFixed;
    logic [31:0] w_nSnap;
    logic [5:0]  w_nRdIdx;
    logic        w_nDio;
    logic        w_nOe;
    logic        w_nDispOn;
    logic [2:0]  w_nBright;
    logic        w_nFrameDone;
    logic        w_nWrote;
    logic        w_dataWe;
    logic [3:0]  w_dataAddr;

    // Strobe starts idle high; clock idles high between bytes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clkSync <= '1;
            r_stbSync <= '1;
            r_dioSync <= '0;
            r_clkPrev <= 1'b1;
            r_stbPrev <= 1'b1;
        end else begin
            r_clkSync <= {r_clkSync[SYNC_STAGES-2:0], i_lk_clk};
            r_stbSync <= {r_stbSync[SYNC_STAGES-2:0], i_lk_stb};
            r_dioSync <= {r_dioSync[SYNC_STAGES-2:0], i_lk_dio};
            r_clkPrev <= r_clkSync[SYNC_STAGES-1];
            r_stbPrev <= r_stbSync[SYNC_STAGES-1];
        end
    end

    assign w_clkCur  = r_clkSync[SYNC_STAGES-1];
    assign w_stbCur  = r_stbSync[SYNC_STAGES-1];
    assign w_dioCur  = r_dioSync[SYNC_STAGES-1];
    assign w_stbFall = r_stbPrev & ~w_stbCur;
    assign w_stbRise = ~r_stbPrev & w_stbCur;
    // Requiring the current strobe low also drops a clock edge that coincides
    // with a strobe rise.
    assign w_clkRise = ~r_clkPrev & w_clkCur & ~w_stbCur;
    assign w_clkFall = r_clkPrev & ~w_clkCur & ~w_stbCur;

    // Bytes arrive LSB first, so each new bit enters at the top.
    assign w_byte = {w_dioCur, r_shift[7:1]};

`ifdef TM1638_KEYSCAN_EN
    assign w_keyState = keys;
`else
    // The key inputs are gated off in this build.
    assign w_keyState = keys & 32'h0000_0000;
`endif

    // Next-state and datapath decode. The clearing sequence suspends the link.
    // A strobe rise or fall overrides any clock edge in the same cycle.
    always_comb begin
        w_nState     = r_state;
        w_nBitCnt    = r_bitCnt;
        w_nShift     = r_shift;
        w_nPtr       = r_ptr;
        w_nFixed     = r_fixed;
        w_nSnap      = r_snap;
        w_nRdIdx     = r_rdIdx;
        w_nDio       = r_dio;
        w_nOe        = r_oe;
        w_nDispOn    = r_dispOn;
        w_nBright    = r_bright;
        w_nFrameDone = 1'b0;
        w_nWrote     = r_wrote;
        w_dataWe     = 1'b0;
        w_dataAddr   = r_ptr;

        if (r_clearing) begin
            w_nState = S_IDLE;
        end else if (w_stbRise) begin
            w_nState     = S_IDLE;
            w_nBitCnt    = 3'd0;
            w_nShift     = 8'h00;
            w_nOe        = 1'b0;
            w_nDio       = 1'b0;
            w_nFrameDone = r_wrote;
            w_nWrote     = 1'b0;
        end else if (w_stbFall) begin
            w_nState  = S_CMD;
            w_nBitCnt = 3'd0;
            w_nShift  = 8'h00;
            w_nWrote  = 1'b0;
            w_nRdIdx  = 6'd0;
        end else begin
            case (r_state)
                S_CMD: begin
                    if (w_clkRise) begin
                        w_nShift  = w_byte;
                        w_nBitCnt = r_bitCnt + 3'd1;
                        if (r_bitCnt == 3'd7) begin
                            case (w_byte[7:6])
                                2'b01: begin
                                    w_nFixed = w_byte[2];
                                    if (w_byte[1]) begin
                                        w_nSnap  = w_keyState;
                                        w_nRdIdx = 6'd0;
                                        w_nState = S_RDATA;
                                    end else begin
                                        w_nState = S_IGNORE;
                                    end
                                end
                                2'b10: begin
                                    w_nDispOn = w_byte[3];
                                    w_nBright = w_byte[2:0];
                                    w_nState  = S_IGNORE;
                                end
                                2'b11: begin
                                    w_nPtr   = w_byte[3:0];
                                    w_nState = S_WDATA;
                                end
                                default: w_nState = S_IGNORE;
                            endcase
                        end
                    end
                end
                S_WDATA: begin
                    if (w_clkRise) begin
                        w_nShift  = w_byte;
                        w_nBitCnt = r_bitCnt + 3'd1;
                        if (r_bitCnt == 3'd7) begin
                            w_dataWe = 1'b1;
                            w_nWrote = 1'b1;
                            if (!r_fixed) begin
                                w_nPtr = r_ptr + 4'd1;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    // Bits past the 32-bit snapshot read as zero.
                    if (w_clkFall) begin
                        w_nOe = 1'b1;
                        if (r_rdIdx < 6'd32) begin
                            w_nDio   = r_snap[r_rdIdx[4:0]];
                            w_nRdIdx = r_rdIdx + 6'd1;
                        end else begin
                            w_nDio = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bitCnt    <= 3'd0;
            r_shift     <= 8'h00;
            r_ptr       <= 4'd0;
            r_fixed     <= 1'b0;
            r_snap      <= 32'h0;
            r_rdIdx     <= 6'd0;
            r_dio       <= 1'b0;
            r_oe        <= 1'b0;
            r_dispOn    <= 1'b0;
            r_bright    <= 3'd0;
            r_frameDone <= 1'b0;
            r_wrote     <= 1'b0;
        end else begin
            r_state     <= w_nState;
            r_bitCnt    <= w_nBitCnt;
            r_shift     <= w_nShift;
            r_ptr       <= w_nPtr;
            r_fixed     <= w_nFixed;
            r_snap      <= w_nSnap;
            r_rdIdx     <= w_nRdIdx;
            r_dio       <= w_nDio;
            r_oe        <= w_nOe;
            r_dispOn    <= w_nDispOn;
            r_bright    <= w_nBright;
            r_frameDone <= w_nFrameDone;
            r_wrote     <= w_nWrote;
        end
    end

    // After reset the RAM is cleared one entry per cycle (16 cycles).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clearing  <= 1'b1;
            r_clearAddr <= 4'd0;
        end else if (r_clearing) begin
            r_clearAddr <= r_clearAddr + 4'd1;
            if (r_clearAddr == 4'd15) begin
                r_clearing <= 1'b0;
            end
        end
    end

    // The RAM has no reset of its own. The clearing sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (r_clearing) begin
            r_ram[r_clearAddr] <= 8'h00;
        end else if (w_dataWe) begin
            r_ram[w_dataAddr] <= w_byte;
        end
    end

    // Read data is held at zero while stale contents are being cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ramRdata <= 8'h00;
        end else if (r_clearing) begin
            r_ramRdata <= 8'h00;
        end else begin
            r_ramRdata <= r_ram[ram_raddr];
        end
    end

    assign o_lk_dio    = r_dio;
    assign o_lk_dio_oe = r_oe;
    assign ram_rdata   = r_ramRdata;
    assign display_on  = r_dispOn;
    assign brightness  = r_bright;
    assign frame_done  = r_frameDone;

endmodule
